// File: rtl/viterbi_ctrl.sv
// Sequencing controller for the Viterbi decoder: accepts symbol pairs, drives the
// shared BMC pair, pulses ACS, writes survivor columns and launches traceback.
module viterbi_ctrl #(
  parameter int TB_LEN = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        rx_pair,
  input  logic              in_last,
  output logic [1:0]        bmc_pair,
  output logic              acs_en,
  output logic              acs_init,
  output logic              sm_wr_en,
  output logic [ADDR_W-1:0] sm_wr_addr,
  output logic              tb_start,
  output logic [ADDR_W-1:0] tb_addr,
  output logic [ADDR_W:0]   tb_cols,
  output logic              tb_flush,
  input  logic              tb_done,
  output logic [1:0]        dbg_state
);

  localparam int SEG_W = ADDR_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACS  = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_TB   = 2'd3;

  localparam logic [SEG_W-1:0]  C_SEG_LAST = SEG_W'(TB_LEN - 1);
  localparam logic [SEG_W-1:0]  C_SEG_ONE  = SEG_W'(1);
  localparam logic [ADDR_W-1:0] C_PTR_ONE  = ADDR_W'(1);

  logic [1:0]        r_state;
  logic [1:0]        r_bmc_pair;
  logic              r_last;
  logic              r_first;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [SEG_W-1:0]  r_seg_cnt;
  logic              r_tb_first;
  logic [ADDR_W-1:0] r_tb_addr;
  logic [SEG_W-1:0]  r_tb_cols;

  logic w_in_idle;
  logic w_in_acs;
  logic w_in_wr;
  logic w_in_tb;
  logic w_accept;
  logic w_seg_end;
  logic w_tb_finish;

  assign w_in_idle   = (r_state == S_IDLE);
  assign w_in_acs    = (r_state == S_ACS);
  assign w_in_wr     = (r_state == S_WR);
  assign w_in_tb     = (r_state == S_TB);
  assign w_accept    = w_in_idle && in_valid;
  assign w_seg_end   = r_last || (r_seg_cnt == C_SEG_LAST);
  // The tb_start cycle itself never completes a traceback.
  assign w_tb_finish = w_in_tb && !r_tb_first && tb_done;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_bmc_pair <= 2'b00;
      r_last     <= 1'b0;
      r_first    <= 1'b1;
      r_wr_ptr   <= '0;
      r_seg_cnt  <= '0;
      r_tb_first <= 1'b0;
      r_tb_addr  <= '0;
      r_tb_cols  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_bmc_pair <= rx_pair;
            r_last     <= in_last;
            r_state    <= S_ACS;
          end
        end
        S_ACS: begin
          r_first <= 1'b0;
          r_state <= S_WR;
        end
        S_WR: begin
          r_wr_ptr  <= r_wr_ptr + C_PTR_ONE;
          r_seg_cnt <= r_seg_cnt + C_SEG_ONE;
          r_tb_addr <= r_wr_ptr;
          r_tb_cols <= r_seg_cnt + C_SEG_ONE;
          if (w_seg_end) begin
            r_tb_first <= 1'b1;
            r_state    <= S_TB;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_TB: begin
          r_tb_first <= 1'b0;
          if (w_tb_finish) begin
            r_seg_cnt <= '0;
            r_state   <= S_IDLE;
            // A flushed frame restarts the survivor memory and the ACS metrics.
            if (r_last) begin
              r_wr_ptr <= '0;
              r_first  <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Handshake: a symbol is consumed on a rising edge where in_valid and in_ready
  // are both 1; the source holds rx_pair/in_last stable until then.
  assign in_ready   = w_in_idle && rst;
  assign bmc_pair   = r_bmc_pair;
  assign acs_en     = w_in_acs;
  assign acs_init   = w_in_acs && r_first;
  assign sm_wr_en   = w_in_wr;
  assign sm_wr_addr = r_wr_ptr;
  assign tb_start   = w_in_tb && r_tb_first;
  assign tb_addr    = r_tb_addr;
  assign tb_cols    = r_tb_cols;
  assign tb_flush   = w_in_tb && r_tb_first && r_last;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_viterbi_ctrl.sv
// Bench for viterbi_ctrl: a transaction-level schedule model predicts every output
// each cycle; directed scenarios add literal expectations on logged events.
module tb_viterbi_ctrl;
  localparam int TB_LEN = 8;
  localparam int AW     = 4;
  localparam int DEPTH  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b1;
  logic          in_ready;
  logic [1:0]    rx_pair = 2'b11;
  logic          in_last = 1'b0;
  logic [1:0]    bmc_pair;
  logic          acs_en, acs_init, sm_wr_en;
  logic [AW-1:0] sm_wr_addr, tb_addr;
  logic [AW:0]   tb_cols;
  logic          tb_start, tb_flush;
  logic          tb_done;
  logic [1:0]    dbg_state;
  logic          r_resp = 1'b0;
  logic          spur_done = 1'b0;

  assign tb_done = r_resp | spur_done;

  viterbi_ctrl #(.TB_LEN(TB_LEN), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rx_pair(rx_pair), .in_last(in_last), .bmc_pair(bmc_pair),
    .acs_en(acs_en), .acs_init(acs_init), .sm_wr_en(sm_wr_en),
    .sm_wr_addr(sm_wr_addr), .tb_start(tb_start), .tb_addr(tb_addr),
    .tb_cols(tb_cols), .tb_flush(tb_flush), .tb_done(tb_done),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;
  int tb_delay = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s timeout at %0t", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Each accepted symbol schedules its response for the following cycles.
  typedef struct packed {
    logic          acs;
    logic          init;
    logic          wr;
    logic [AW-1:0] addr;
    logic          tbs;
    logic [AW-1:0] taddr;
    logic [AW:0]   cols;
    logic          flush;
  } exp_t;

  exp_t       exp_q[$];
  bit         m_wait  = 1'b0;
  bit         m_first = 1'b1;
  bit         m_flush = 1'b0;
  int         m_ptr   = 0;
  int         m_cnt   = 0;
  logic [1:0] m_bmc   = 2'b00;

  logic [31:0] wr_q[$], init_q[$], bmc_q[$], acs_cyc_q[$], wr_cyc_q[$];
  logic [31:0] tb_addr_q[$], tb_cols_q[$], tb_flush_q[$], tbs_cyc_q[$];

  always @(negedge clk) begin
    exp_t e;
    exp_t n;
    bit   have;
    bit   idle;
    have = (exp_q.size() > 0);
    e    = have ? exp_q[0] : '0;
    idle = !have && !m_wait;
    if (chk_en) begin
      check("in_ready", in_ready, idle && rst);
      check("acs_en", acs_en, e.acs);
      check("acs_init", acs_init, e.acs && e.init);
      check("sm_wr_en", sm_wr_en, e.wr);
      if (e.wr) check("sm_wr_addr", sm_wr_addr, e.addr);
      check("tb_start", tb_start, e.tbs);
      check("tb_flush", tb_flush, e.tbs && e.flush);
      if (e.tbs) begin
        check("tb_addr", tb_addr, e.taddr);
        check("tb_cols", tb_cols, e.cols);
      end
      check("bmc_pair", bmc_pair, m_bmc);
      if (acs_en === 1'b1) begin
        init_q.push_back(acs_init);
        bmc_q.push_back(bmc_pair);
        acs_cyc_q.push_back(cyc);
      end
      if (sm_wr_en === 1'b1) begin
        wr_q.push_back(sm_wr_addr);
        wr_cyc_q.push_back(cyc);
      end
      if (tb_start === 1'b1) begin
        tb_addr_q.push_back(tb_addr);
        tb_cols_q.push_back(tb_cols);
        tb_flush_q.push_back(tb_flush);
        tbs_cyc_q.push_back(cyc);
      end
    end
    // advance the model to the next cycle
    if (have) begin
      void'(exp_q.pop_front());
      if (e.tbs) m_wait = 1'b1;
    end else if (m_wait) begin
      if (tb_done === 1'b1) begin
        m_wait = 1'b0;
        m_cnt  = 0;
        if (m_flush) begin
          m_ptr   = 0;
          m_first = 1'b1;
        end
      end
    end else if (in_valid === 1'b1 && rst === 1'b1) begin
      m_bmc = rx_pair;
      n = '0; n.acs = 1'b1; n.init = m_first;
      exp_q.push_back(n);
      n = '0; n.wr = 1'b1; n.addr = AW'(m_ptr);
      exp_q.push_back(n);
      if (in_last || (m_cnt + 1 == TB_LEN)) begin
        n = '0; n.tbs = 1'b1; n.taddr = AW'(m_ptr); n.cols = (AW+1)'(m_cnt + 1);
        n.flush = in_last;
        exp_q.push_back(n);
        m_flush = in_last;
      end
      m_first = 1'b0;
      m_ptr   = (m_ptr + 1) % DEPTH;
      m_cnt   = m_cnt + 1;
    end
    if (rst !== 1'b1) begin
      exp_q.delete();
      m_wait  = 1'b0;
      m_first = 1'b1;
      m_ptr   = 0;
      m_cnt   = 0;
      m_bmc   = 2'b00;
    end
  end

  // ---------------- traceback responder ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && tb_start === 1'b1) begin
        repeat (tb_delay) @(posedge clk);
        #1 r_resp = 1'b1;
        @(posedge clk);
        #1 r_resp = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  int last_acc = 0;

  task automatic send(input logic [1:0] p, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    rx_pair  = p;
    in_last  = l;
    forever begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      n++;
      if (n > 200) begin
        timeout("send");
        break;
      end
    end
    last_acc = cyc;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      n++;
      if (n > 200) begin
        timeout("wait_idle");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_q.delete(); init_q.delete(); bmc_q.delete(); acs_cyc_q.delete();
    wr_cyc_q.delete(); tb_addr_q.delete(); tb_cols_q.delete();
    tb_flush_q.delete(); tbs_cyc_q.delete();
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int acc;
    int n;
    // reset held two edges with a symbol offered
    @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_bmc", bmc_pair, 2'b00);
    check("rst_pulses", {acs_en, acs_init, sm_wr_en, tb_start, tb_flush}, 5'b0);
    check("rst_addrs", {sm_wr_addr, tb_addr, tb_cols}, '0);
    @(posedge clk);
    #1 rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("rel_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // single-symbol frame
    clear_logs();
    send(2'b10, 1'b1);
    acc = last_acc;
    wait_idle();
    check("ss_acs_cyc", acs_cyc_q[0], acc + 1);
    check("ss_bmc", bmc_q[0], 2'b10);
    check("ss_init", init_q[0], 1);
    check("ss_wr_cyc", wr_cyc_q[0], acc + 2);
    check("ss_wr_addr", wr_q[0], 0);
    check("ss_tbs_cyc", tbs_cyc_q[0], acc + 3);
    check("ss_tb", {tb_addr_q[0][3:0], tb_cols_q[0][4:0], tb_flush_q[0][0]}, {4'd0, 5'd1, 1'b1});
    send(2'b01, 1'b1);
    wait_idle();
    check("ss2_init", init_q[1], 1);
    check("ss2_wr_addr", wr_q[1], 0);

    // one full segment without last, then close the frame
    clear_logs();
    for (int i = 0; i < 8; i++) send(2'($urandom_range(0, 3)), 1'b0);
    wait_idle();
    for (int i = 0; i < 8; i++) begin
      check("seg_wr_addr", wr_q[i], i);
      check("seg_init", init_q[i], (i == 0) ? 1 : 0);
    end
    check("seg_tb_cnt", tb_addr_q.size(), 1);
    check("seg_tb", {tb_addr_q[0][3:0], tb_cols_q[0][4:0], tb_flush_q[0][0]}, {4'd7, 5'd8, 1'b0});
    send(2'b00, 1'b1);
    wait_idle();

    // wrap through the survivor memory
    clear_logs();
    for (int i = 0; i < 20; i++) send(2'($urandom_range(0, 3)), (i == 19) ? 1'b1 : 1'b0);
    wait_idle();
    check("wrap_wr_cnt", wr_q.size(), 20);
    for (int i = 0; i < 20; i++) check("wrap_wr_addr", wr_q[i], (i < 16) ? i : i - 16);
    check("wrap_tb_cnt", tb_addr_q.size(), 3);
    check("wrap_tb0", {tb_addr_q[0][3:0], tb_cols_q[0][4:0], tb_flush_q[0][0]}, {4'd7, 5'd8, 1'b0});
    check("wrap_tb1", {tb_addr_q[1][3:0], tb_cols_q[1][4:0], tb_flush_q[1][0]}, {4'd15, 5'd8, 1'b0});
    check("wrap_tb2", {tb_addr_q[2][3:0], tb_cols_q[2][4:0], tb_flush_q[2][0]}, {4'd3, 5'd4, 1'b1});

    // traceback stall with the next symbol already offered
    clear_logs();
    tb_delay = 6;
    send(2'b01, 1'b1);
    send(2'b10, 1'b0);
    wait_idle();
    check("stall_acs_cyc", acs_cyc_q[1], tbs_cyc_q[0] + 6 + 2);
    check("stall_wr_cyc", wr_cyc_q[1], acs_cyc_q[1] + 1);
    tb_delay = 1;
    repeat (2) @(posedge clk);
    #1 spur_done = 1'b1;
    @(posedge clk);
    #1 spur_done = 1'b0;
    send(2'b11, 1'b1);
    wait_idle();
    check("spur_tb", {tb_addr_q[1][3:0], tb_cols_q[1][4:0], tb_flush_q[1][0]}, {4'd1, 5'd2, 1'b1});

    // reset while a traceback is pending
    clear_logs();
    tb_delay = 12;
    for (int i = 0; i < 8; i++) send(2'($urandom_range(0, 3)), 1'b0);
    n = 0;
    while (tbs_cyc_q.size() == 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (tbs_cyc_q.size() == 0) timeout("mid_tb_start");
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", in_ready, 1'b1);
    send(2'b01, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check("mid_rst_init", init_q[8], 1);
    check("mid_rst_addr", wr_q[8], 0);
    check("mid_rst_no_tbs", tb_addr_q.size(), 1);
    tb_delay = 1;
    send(2'b00, 1'b1);
    wait_idle();

    // randomized traffic, checked cycle by cycle against the model
    for (int i = 0; i < 300; i++) begin
      tb_delay = $urandom_range(1, 4);
      send(2'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      if (i % 50 == 49) begin
        wait_idle();
        spur_done = 1'b1;
        @(posedge clk);
        #1 spur_done = 1'b0;
      end
    end
    wait_idle();
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
